// File: rtl/nibble_pkg.sv
// rtl/nibble_pkg.sv - shared opcodes, ALU selects and sequencer states for the nibble processor
package nibble_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;

endpackage

// File: rtl/nibble_decoder.sv
// rtl/nibble_decoder.sv - combinational opcode decode into strobes and control flags
module nibble_decoder
    import nibble_pkg::*;
(
    input  logic [3:0] opcode_i,
    output logic       acc_we_o,
    output logic [2:0] alu_op_o,
    output logic       out_we_o,
    output logic       jump_o,
    output logic       cond_o,
    output logic       halt_o,
    output logic       illegal_o
);

    // Map each opcode to its control set; anything unlisted is illegal.
    always_comb begin
        acc_we_o  = 1'b0;
        alu_op_o  = ALU_PASS;
        out_we_o  = 1'b0;
        jump_o    = 1'b0;
        cond_o    = 1'b0;
        halt_o    = 1'b0;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_NOP: ;
            OP_LDI: begin acc_we_o = 1'b1; alu_op_o = ALU_PASS; end
            OP_ADD: begin acc_we_o = 1'b1; alu_op_o = ALU_ADD;  end
            OP_SUB: begin acc_we_o = 1'b1; alu_op_o = ALU_SUB;  end
            OP_AND: begin acc_we_o = 1'b1; alu_op_o = ALU_AND;  end
            OP_OR:  begin acc_we_o = 1'b1; alu_op_o = ALU_OR;   end
            OP_JMP: jump_o   = 1'b1;
            OP_JZ:  cond_o   = 1'b1;
            OP_OUT: out_we_o = 1'b1;
            OP_HLT: halt_o   = 1'b1;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/nibble_sequencer.sv
// rtl/nibble_sequencer.sv - fetch/decode/execute sequencer with program counter, jumps and halt
module nibble_sequencer
    import nibble_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    input  logic              acc_zero,
    output logic              acc_we,
    output logic [2:0]        alu_op,
    output logic [3:0]        imm,
    output logic              out_we,
    output logic              busy,
    output logic              halted,
    output logic              err
);

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [7:0]        ir_q;
    logic              err_q;

    logic       dec_acc_we;
    logic [2:0] dec_alu_op;
    logic       dec_out_we;
    logic       dec_jump;
    logic       dec_cond;
    logic       dec_halt;
    logic       dec_illegal;
    logic       in_exec;

    nibble_decoder u_decoder (
        .opcode_i  (ir_q[7:4]),
        .acc_we_o  (dec_acc_we),
        .alu_op_o  (dec_alu_op),
        .out_we_o  (dec_out_we),
        .jump_o    (dec_jump),
        .cond_o    (dec_cond),
        .halt_o    (dec_halt),
        .illegal_o (dec_illegal)
    );

    // Sequencer state, program counter, instruction register and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        ir_q    <= mem_rdata;
                        pc_q    <= pc_q + ADDR_W'(1);
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec_illegal) begin
                        err_q   <= 1'b1;
                        state_q <= S_HALT;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // acc_zero is sampled only here, so it reaches nothing but the PC.
                    if (dec_jump || (dec_cond && acc_zero)) pc_q <= ADDR_W'(ir_q[3:0]);
                    state_q <= dec_halt ? S_HALT : S_FETCH;
                end
                S_HALT: ;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs decode only registered state and IR; strobes are gated to the EXEC cycle.
    assign in_exec  = (state_q == S_EXEC);
    assign mem_req  = (state_q == S_FETCH);
    assign mem_addr = pc_q;
    assign acc_we   = in_exec & dec_acc_we;
    assign alu_op   = in_exec ? dec_alu_op : ALU_PASS;
    assign out_we   = in_exec & dec_out_we;
    assign imm      = ir_q[3:0];
    assign busy     = (state_q == S_FETCH) || (state_q == S_DECODE) || in_exec;
    assign halted   = (state_q == S_HALT);
    assign err      = err_q;

endmodule

// File: tb/tb_nibble_sequencer.sv
// tb/tb_nibble_sequencer.sv - self-checking bench with program-level reference model
`timescale 1ns/1ps
module tb_nibble_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       mem_req;
    logic [3:0] mem_addr;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic       acc_zero = 1'b0;
    logic       acc_we;
    logic [2:0] alu_op;
    logic [3:0] imm;
    logic       out_we;
    logic       busy;
    logic       halted;
    logic       err;

    int errors = 0;
    int checks = 0;

    logic [7:0]  prog [16];
    logic [16:0] exp_q [$];
    int          mem_waits = 0;
    int          wait_cnt = 0;
    logic        force_ack = 1'b0;

    nibble_sequencer #(.ADDR_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .acc_zero  (acc_zero),
        .acc_we    (acc_we),
        .alu_op    (alu_op),
        .imm       (imm),
        .out_we    (out_we),
        .busy      (busy),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Program memory: acknowledges after mem_waits idle request cycles.
    always @(negedge clk) begin
        if (reset || !mem_req) begin
            wait_cnt = 0;
            mem_ack  = force_ack;
        end else if (wait_cnt == mem_waits) begin
            mem_ack   = 1'b1;
            mem_rdata = prog[mem_addr];
            wait_cnt  = 0;
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = wait_cnt + 1;
        end
    end

    // Vector layout: req[16] addr[15:12] acc_we[11] alu[10:8] imm[7:4] out_we[3] busy[2] halted[1] err[0]
    function automatic logic [16:0] mk(input logic rq, input logic [3:0] ad, input logic we,
                                       input logic [2:0] al, input logic [3:0] im, input logic ow,
                                       input logic bz, input logic ht, input logic er);
        return {rq, ad, we, al, im, ow, bz, ht, er};
    endfunction

    function automatic logic [16:0] dut_vec();
        return mk(mem_req, mem_addr, acc_we, alu_op, imm, out_we, busy, halted, err);
    endfunction

    // Interpret the program instruction by instruction and emit the cycle trace it implies.
    task automatic build_model(input int waits, input logic az, input int ncyc);
        int pc = 0;
        logic [7:0] ir = 8'h00;
        logic stop = 1'b0;
        logic e = 1'b0;
        exp_q.delete();
        while (exp_q.size() < ncyc) begin
            if (stop) begin
                exp_q.push_back(mk(0, 4'(pc), 0, 0, ir[3:0], 0, 0, 1, e));
            end else begin
                int op;
                logic we = 0, ow = 0;
                logic [2:0] al = 3'd0;
                for (int w = 0; w <= waits; w++)
                    exp_q.push_back(mk(1, 4'(pc), 0, 0, ir[3:0], 0, 1, 0, e));
                ir = prog[pc];
                pc = (pc + 1) % 16;
                op = int'(ir[7:4]);
                exp_q.push_back(mk(0, 4'(pc), 0, 0, ir[3:0], 0, 1, 0, e));
                if (op >= 9 && op <= 14) begin
                    e = 1'b1;
                    stop = 1'b1;
                end else begin
                    if (op >= 1 && op <= 5) begin
                        we = 1'b1;
                        al = 3'(op - 1);
                    end
                    if (op == 8) ow = 1'b1;
                    exp_q.push_back(mk(0, 4'(pc), we, al, ir[3:0], ow, 1, 0, e));
                    if (op == 6 || (op == 7 && az)) pc = int'(ir[3:0]);
                    if (op == 15) stop = 1'b1;
                end
            end
        end
    endtask

    task automatic check_vec(input string name, input int cyc, input logic [16:0] act, input logic [16:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %05h expected %05h", name, cyc, act, want);
        end
    endtask

    task automatic pin(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic fill_prog(input logic [7:0] v);
        for (int i = 0; i < 16; i++) prog[i] = v;
    endtask

    // Reset, start, then compare every cycle against the model trace.
    task automatic run(input string name, input int waits, input logic az, input int ncyc, input logic stray);
        build_model(waits, az, ncyc);
        mem_waits = waits;
        acc_zero  = az;
        force_ack = 1'b0;
        start     = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_vec({name, "_reset"}, -1, dut_vec(), 17'h0);
        start = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            force_ack = stray && (i >= 3) && (i % 2 == 1);
            @(negedge clk);
            check_vec(name, i, dut_vec(), exp_q[i]);
        end
        force_ack = 1'b0;
        start     = 1'b0;
    endtask

    function automatic int field(input int idx, input int lsb, input int width);
        return int'((exp_q[idx] >> lsb) & ((17'h1 << width) - 1));
    endfunction

    initial begin
        int n;

        fill_prog(8'hF0);
        prog[0] = 8'h15; prog[1] = 8'h23; prog[2] = 8'h80; prog[3] = 8'hF0;
        run("prog4", 0, 1'b0, 16, 1'b0);
        pin("prog4_ldi_we", field(2, 11, 1), 1);
        pin("prog4_ldi_imm", field(2, 4, 4), 5);
        pin("prog4_add_alu", field(5, 8, 3), 1);
        pin("prog4_add_imm", field(5, 4, 4), 3);
        n = 0; foreach (exp_q[i]) n += field(i, 11, 1);
        pin("prog4_acc_we_count", n, 2);
        n = 0; foreach (exp_q[i]) n += field(i, 3, 1);
        pin("prog4_out_we_count", n, 1);
        pin("prog4_halt_at_11", field(11, 1, 1), 0);
        pin("prog4_halt_at_12", field(12, 1, 1), 1);
        pin("prog4_err", field(15, 0, 1), 0);

        run("wait3", 3, 1'b0, 30, 1'b0);
        pin("wait3_req_c3", field(3, 16, 1), 1);
        pin("wait3_req_c4", field(4, 16, 1), 0);
        pin("wait3_fetch2_c6", field(6, 16, 1), 1);
        pin("wait3_halt_c24", field(24, 1, 1), 1);

        fill_prog(8'hF0);
        prog[0] = 8'h7A;
        run("jz_taken", 0, 1'b1, 8, 1'b0);
        pin("jz_taken_addr", field(3, 12, 4), 10);
        run("jz_not_taken", 0, 1'b0, 8, 1'b0);
        pin("jz_not_taken_addr", field(3, 12, 4), 1);

        fill_prog(8'h00);
        run("wrap16", 0, 1'b0, 51, 1'b0);
        pin("wrap16_addr_c45", field(45, 12, 4), 15);
        pin("wrap16_addr_c48", field(48, 12, 4), 0);
        pin("wrap16_req_c48", field(48, 16, 1), 1);

        prog[15] = 8'h60;
        run("jmp_from_15", 0, 1'b0, 51, 1'b0);

        fill_prog(8'h00);
        prog[2] = 8'h60;
        run("jmp0_from_2", 0, 1'b0, 12, 1'b0);
        pin("jmp0_addr_c9", field(9, 12, 4), 0);

        fill_prog(8'h00);
        prog[0] = 8'h95;
        run("illegal", 0, 1'b0, 12, 1'b1);
        pin("illegal_err_c2", field(2, 0, 1), 1);
        pin("illegal_halt_c2", field(2, 1, 1), 1);
        n = 0; foreach (exp_q[i]) n += field(i, 11, 1) + field(i, 3, 1);
        pin("illegal_no_strobes", n, 0);

        // Asynchronous reset while the second fetch waits for its acknowledge.
        fill_prog(8'h00);
        mem_waits = 5;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 10; i++) @(negedge clk);
        check_vec("midfetch_pre", 10, {mem_req, mem_addr}, {1'b1, 4'h1});
        #2 reset = 1'b1;
        #1 check_vec("midfetch_async", 0, {mem_req, mem_addr, busy}, 6'h0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        force_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_vec("late_ack", i, dut_vec(), 17'h0);
        end
        force_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_sequencer.md
# nibble_sequencer

Multi-cycle instruction sequencer for the nibble processor. Fetches 8-bit instructions from program memory through a req/ack handshake, holds them in an instruction register, decodes the 4-bit opcode and drives one-cycle control strobes into the 4-bit accumulator/ALU datapath. It also owns the program counter and implements jumps and halt. It replaces the fixed three-state control with a full fetch/decode/execute sequencer.

## Interface
Parameters:
- `ADDR_W`, 4: program counter and memory address width; PC wraps modulo 2^ADDR_W.

Ports (clock and reset first):
- `clk`  in  1  system clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  level; leaves IDLE when high.
- `mem_req`  out  1  fetch request, held high until acknowledged.
- `mem_addr`  out  ADDR_W  fetch address (= PC).
- `mem_ack`  in  1  memory acknowledge; rdata valid in the same cycle.
- `mem_rdata`  in  8  instruction: [7:4] opcode, [3:0] operand.
- `acc_zero`  in  1  datapath accumulator-equals-zero flag.
- `acc_we`  out  1  accumulator write strobe.
- `alu_op`  out  3  datapath function select.
- `imm`  out  4  operand nibble to datapath.
- `out_we`  out  1  output-port write strobe.
- `busy`  out  1  high in FETCH/DECODE/EXEC.
- `halted`  out  1  high in HALT.
- `err`  out  1  sticky; set on illegal opcode.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALT (3-bit encoding).
- IDLE: outputs inactive. `start`=1 → FETCH next cycle.
- FETCH: `mem_req`=1, `mem_addr`=PC. On a `mem_ack`=1 edge: IR ← `mem_rdata`, PC ← PC+1 (15→0 wrap), → DECODE. Without ack, stay in FETCH with `mem_req` held.
- DECODE: one cycle, no strobes. An illegal opcode sets `err` and goes to HALT; otherwise → EXEC.
- EXEC: one cycle. Strobes are driven from IR; next state is FETCH, except HLT → HALT.
  - 0 NOP: nothing.
  - 1 LDI: `acc_we`, `alu_op`=PASS.
  - 2 ADD: `acc_we`, `alu_op`=ADD.
  - 3 SUB: `acc_we`, `alu_op`=SUB.
  - 4 AND: `acc_we`, `alu_op`=AND.
  - 5 OR: `acc_we`, `alu_op`=OR.
  - 6 JMP: PC ← operand.
  - 7 JZ: PC ← operand if `acc_zero`=1 in the EXEC cycle; else PC unchanged.
  - 8 OUT: `out_we`.
  - F HLT: → HALT.
  - 9–E: illegal (caught in DECODE).
- `imm` = IR[3:0] in every state. `alu_op`=PASS (0) outside EXEC.
- HALT: absorbing. Only `reset` exits. `start` is ignored.
- `mem_ack` outside FETCH is ignored and causes no state change.
- Jump target 0 is legal. JZ with PC wrapped to 0 behaves normally.

## Timing
- Reset values: state=IDLE, PC=0, IR=0x00, `err`=0. All outputs 0; `mem_addr`=0.
- Reset is asynchronous. Asserting it mid-FETCH drops `mem_req` immediately, without waiting for the clock. A later `mem_ack` is ignored.
- Minimum instruction time is 3 cycles (ack in the first FETCH cycle). Each wait cycle adds one.
- Strobes `acc_we` and `out_we` are exactly one cycle wide, during EXEC only.
- Back-to-back instructions: `mem_req` rises in the cycle after EXEC.
- A PC update from JMP/JZ is visible on `mem_addr` in the following FETCH.
- All outputs are decoded from registered state/IR. There are no input-to-output combinational paths except through `acc_zero`, which affects only the next PC.

## Structure
- Shared package `nibble_pkg` holds:
  - opcode constants (OP_NOP … OP_HLT);
  - `alu_op` encodings PASS=0, ADD=1, SUB=2, AND=3, OR=4;
  - state encodings.
- The datapath imports the same ALU encodings from `nibble_pkg`.
- One combinational sub-module, `nibble_decoder`: takes IR[7:4] and produces the strobe set, jump/cond/halt/illegal flags. The sequencer gates these with the EXEC state.

## Test plan
- Reset, then `start`=1, memory acks immediately, program [0x15, 0x23, 0x80, 0xF0] → `acc_we` with `imm`=5 (PASS), then with `imm`=3 (ADD), `out_we` once, `halted`=1 after 12 cycles, `err`=0.
- Memory inserts 3 wait cycles per fetch → `mem_req` held 4 cycles per fetch, `mem_addr` stable, each instruction takes 6 cycles.
- JZ: 0x7A with `acc_zero`=1 → next `mem_addr`=0xA. Same instruction with `acc_zero`=0 → next `mem_addr`=PC+1.
- PC wrap: 16 NOPs from address 0 → 17th fetch has `mem_addr`=0. JMP 0x0 from address 15 → `mem_addr`=0.
- Illegal opcode 0x9x → no strobes, `err`=1, `halted`=1. `start` and `mem_ack` pulses have no effect afterwards.
- `reset` asserted mid-FETCH while waiting for ack → `mem_req`=0 immediately, PC=0, state IDLE. A late `mem_ack` is ignored.
